// File: rtl/knn_pkg.sv
// Shared definitions for the classifier reporting path: frame constants,
// flag bit positions and the UART transmitter state encoding.
package knn_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         FLAG_CLASS_BIT = 0;
  localparam int         FLAG_KMODE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. A byte is taken when i_valid and o_ready
// are both high. o_ready is high in IDLE and in the very last cycle of the
// stop bit, so a following byte starts with no idle gap between frames.
module uart_tx_byte
  import knn_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int             TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_busy;
  logic          w_bit_end;

  assign w_bit_end = (r_timer == BIT_LAST);

  // Next-state logic: bit timer, bit index, shift register and line level.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    o_ready       = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready  = 1'b1;
        w_tx_nxt = 1'b1;
        if (i_valid) begin
          w_state_nxt = START;
          w_shift_nxt = i_data;
          w_timer_nxt = '0;
          w_tx_nxt    = 1'b0;
        end else begin
          w_timer_nxt = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_timer_nxt   = '0;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = STOP;
            w_bit_idx_nxt = 3'd0;
            w_tx_nxt      = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          o_ready     = 1'b1;
          w_timer_nxt = '0;
          if (i_valid) begin
            w_state_nxt = START;
            w_shift_nxt = i_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_timer_nxt   = '0;
        w_bit_idx_nxt = 3'd0;
        w_tx_nxt      = 1'b1;
      end
    endcase
  end

  // State and output registers; busy is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;

endmodule

// File: rtl/result_uart_tx.sv
// Result reporter: snapshots the classifier result on report and sends it
// as a fixed binary frame (A5, x, y, flags, latency hi, latency lo) over
// a UART line. Defining RESULT_UART_TX_CHECKSUM_EN appends a 7th byte, the
// XOR of bytes 1..5. Reports arriving while a frame is in flight are
// dropped and flagged for one cycle.
module result_uart_tx
  import knn_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        report,
  input  logic [7:0]  x_value,
  input  logic [7:0]  y_value,
  input  logic        predicted_class,
  input  logic        k_mode,
  input  logic [15:0] latency,
  output logic        tx,
  output logic        busy,
  output logic        dropped
);

  // Must come out at 2 or more for the serialiser timer to be meaningful.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef RESULT_UART_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 7;
`else
  localparam int FRAME_BYTES = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  logic       w_ser_busy, w_ser_ready, w_ser_tx, w_ser_valid;
  logic       w_accept, w_drop, w_last_byte, w_next_req;
  logic [7:0] w_ser_data, w_flags, w_next_byte;
  logic [2:0] w_next_idx;

  logic [7:0] r_x, r_y, r_flags, r_lat_hi, r_lat_lo;
  logic [2:0] r_byte_idx;
  logic       r_dropped;

`ifdef RESULT_UART_TX_CHECKSUM_EN
  logic [7:0] w_checksum;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                input logic [7:0] b3, input logic [7:0] b4,
                                                input logic [7:0] b5);
    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
  endfunction

  assign w_checksum = frame_checksum(r_x, r_y, r_flags, r_lat_hi, r_lat_lo);
`endif

  // Only an idle transmitter may take a new frame; otherwise flag a drop.
  assign w_accept    = report & ~w_ser_busy;
  assign w_drop      = report &  w_ser_busy;
  assign w_last_byte = (r_byte_idx == LAST_IDX);
  assign w_next_req  = w_ser_busy & w_ser_ready & ~w_last_byte;
  assign w_next_idx  = r_byte_idx + 3'd1;

  // The sync byte is fed straight through on accept so the start bit
  // appears the cycle after the accepting edge.
  assign w_ser_valid = w_accept | w_next_req;
  assign w_ser_data  = w_accept ? SYNC_BYTE : w_next_byte;

  // Pack the flags byte from the live inputs for capture.
  always_comb begin
    w_flags                 = 8'h00;
    w_flags[FLAG_CLASS_BIT] = predicted_class;
    w_flags[FLAG_KMODE_BIT] = k_mode;
  end

  // Select the frame byte that follows the one currently on the line.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      3'd0:    w_next_byte = SYNC_BYTE;
      3'd1:    w_next_byte = r_x;
      3'd2:    w_next_byte = r_y;
      3'd3:    w_next_byte = r_flags;
      3'd4:    w_next_byte = r_lat_hi;
      3'd5:    w_next_byte = r_lat_lo;
`ifdef RESULT_UART_TX_CHECKSUM_EN
      3'd6:    w_next_byte = w_checksum;
`endif
      default: w_next_byte = 8'h00;
    endcase
  end

  // Snapshot register: frozen for the whole frame once a report is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x      <= 8'h00;
      r_y      <= 8'h00;
      r_flags  <= 8'h00;
      r_lat_hi <= 8'h00;
      r_lat_lo <= 8'h00;
    end else if (w_accept) begin
      r_x      <= x_value;
      r_y      <= y_value;
      r_flags  <= w_flags;
      r_lat_hi <= latency[15:8];
      r_lat_lo <= latency[7:0];
    end
  end

  // Byte sequencer: index of the byte currently being serialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_idx <= 3'd0;
    end else if (w_accept) begin
      r_byte_idx <= 3'd0;
    end else if (w_ser_busy && w_ser_ready) begin
      r_byte_idx <= w_last_byte ? 3'd0 : w_next_idx;
    end
  end

  // One-cycle dropped pulse for a report that arrived mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_drop;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .reset  (reset),
    .i_valid(w_ser_valid),
    .i_data (w_ser_data),
    .o_ready(w_ser_ready),
    .o_tx   (w_ser_tx),
    .o_busy (w_ser_busy)
  );

  assign tx      = w_ser_tx;
  assign busy    = w_ser_busy;
  assign dropped = r_dropped;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx at CLKS_PER_BIT = 16. The line is
// recorded cycle by cycle while busy and decoded as 8N1 at mid-bit points.
module tb_result_uart_tx;

  localparam int CPB  = 16;
  localparam int BITC = 10 * CPB;
`ifdef RESULT_UART_TX_CHECKSUM_EN
  localparam int FB = 7;
`else
  localparam int FB = 6;
`endif
  localparam int BUDGET = FB * BITC + 50;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        cls;
    logic        k;
    logic [15:0] lat;
    logic [55:0] expb;  // byte b at [8*b +: 8], byte 0 is sync
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        report = 1'b0;
  logic [7:0]  x_value = 8'h00;
  logic [7:0]  y_value = 8'h00;
  logic        predicted_class = 1'b0;
  logic        k_mode = 1'b0;
  logic [15:0] latency = 16'h0000;
  logic        tx, busy, dropped;

  int tests = 0;
  int fails = 0;

  result_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .report         (report),
    .x_value        (x_value),
    .y_value        (y_value),
    .predicted_class(predicted_class),
    .k_mode         (k_mode),
    .latency        (latency),
    .tx             (tx),
    .busy           (busy),
    .dropped        (dropped)
  );

  always #5 clk = ~clk;

  // Reference frame straight from the frame layout rules.
  function automatic logic [55:0] model_frame(input logic [7:0] x, input logic [7:0] y,
                                              input logic c, input logic k,
                                              input logic [15:0] lat);
    logic [7:0] b [7];
    logic [55:0] r;
    b[0] = 8'hA5;
    b[1] = x;
    b[2] = y;
    b[3] = {6'b000000, k, c};
    b[4] = lat[15:8];
    b[5] = lat[7:0];
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    r = '0;
    for (int i = 0; i < 7; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    x_value = v.x;
    y_value = v.y;
    predicted_class = v.cls;
    k_mode = v.k;
    latency = v.lat;
  endtask

  // Called on a negedge; report is sampled at the following posedge.
  task automatic pulse_report(input string nm);
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
    chk({nm, "_start_bit"}, 32'(tx), 32'd0);
  endtask

  // Records tx while busy; optionally pulses report at given busy cycles.
  task automatic capture(input int drop_a, input int drop_b, output logic [55:0] got,
                         output int bcyc, output int ndrop, output int ferr);
    logic s [$];
    int cnt;
    cnt = 0;
    ndrop = 0;
    ferr = 0;
    got = '0;
    while (busy === 1'b1 && cnt < BUDGET) begin
      if (dropped === 1'b1) ndrop++;
      s.push_back(tx);
      report = (cnt == drop_a || cnt == drop_b);
      cnt++;
      @(negedge clk);
    end
    report = 1'b0;
    if (dropped === 1'b1) ndrop++;
    bcyc = cnt;
    for (int b = 0; b < FB; b++) begin
      if (b * BITC + BITC <= s.size()) begin
        if (s[b*BITC + CPB/2] !== 1'b0) ferr++;
        if (s[b*BITC + 9*CPB + CPB/2] !== 1'b1) ferr++;
        for (int i = 0; i < 8; i++) got[8*b + i] = s[b*BITC + (1+i)*CPB + CPB/2];
      end else begin
        ferr++;
        got[8*b +: 8] = 8'hxx;
      end
    end
  endtask

  task automatic check_frame(input string nm, input logic [55:0] got, input logic [55:0] exp,
                             input int bcyc, input int ferr, input int ndrop, input int exp_drop);
    for (int b = 0; b < FB; b++)
      chk($sformatf("%s_byte%0d", nm, b), 32'(got[8*b +: 8]), 32'(exp[8*b +: 8]));
    chk({nm, "_busy_len"}, 32'(bcyc), 32'(FB * BITC));
    chk({nm, "_framing"}, 32'(ferr), 32'd0);
    chk({nm, "_drops"}, 32'(ndrop), 32'(exp_drop));
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v, w;
    logic [55:0] got;
    int bcyc, ndrop, ferr, extra;

    tbl[0] = '{x: 8'h12, y: 8'hF0, cls: 1'b1, k: 1'b1, lat: 16'h0044,
               expb: 56'hA5_44_00_03_F0_12_A5};
    tbl[1] = '{x: 8'h80, y: 8'h7F, cls: 1'b0, k: 1'b0, lat: 16'hFFFF,
               expb: 56'hFF_FF_FF_00_7F_80_A5};
    for (int i = 2; i < 8; i++) begin
      tbl[i].x   = 8'($urandom);
      tbl[i].y   = 8'($urandom);
      tbl[i].cls = 1'($urandom);
      tbl[i].k   = 1'($urandom);
      tbl[i].lat = 16'($urandom);
      tbl[i].expb = model_frame(tbl[i].x, tbl[i].y, tbl[i].cls, tbl[i].k, tbl[i].lat);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames (directed + random)
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      pulse_report($sformatf("vec%0d", i));
      capture(-1, -1, got, bcyc, ndrop, ferr);
      check_frame($sformatf("vec%0d", i), got, tbl[i].expb, bcyc, ferr, ndrop, 0);
      repeat (3) @(negedge clk);
    end

    // Inputs change right after accept: frame keeps the snapshot
    v.x = 8'($urandom); v.y = 8'($urandom); v.cls = 1'($urandom);
    v.k = 1'($urandom); v.lat = 16'($urandom);
    w.x = ~v.x; w.y = ~v.y; w.cls = ~v.cls; w.k = ~v.k; w.lat = ~v.lat;
    drive(v);
    pulse_report("snap");
    drive(w);
    capture(-1, -1, got, bcyc, ndrop, ferr);
    check_frame("snap", got, model_frame(v.x, v.y, v.cls, v.k, v.lat), bcyc, ferr, ndrop, 0);
    repeat (3) @(negedge clk);

    // Reports during busy cycle 5 and the final stop cycle are dropped
    drive(tbl[0]);
    pulse_report("drop");
    capture(5, FB * BITC - 1, got, bcyc, ndrop, ferr);
    check_frame("drop", got, tbl[0].expb, bcyc, ferr, ndrop, 2);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
      @(negedge clk);
    end
    chk("drop_no_second_frame", 32'(extra), 32'd0);

    // Back-to-back: report in the first idle cycle after a frame
    drive(tbl[1]);
    pulse_report("b2b_a");
    capture(-1, -1, got, bcyc, ndrop, ferr);
    check_frame("b2b_a", got, tbl[1].expb, bcyc, ferr, ndrop, 0);
    drive(tbl[0]);
    pulse_report("b2b_b");
    capture(-1, -1, got, bcyc, ndrop, ferr);
    check_frame("b2b_b", got, tbl[0].expb, bcyc, ferr, ndrop, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in DATA, bit 3 of the sync byte (bit value 0)
    drive(tbl[0]);
    pulse_report("arst");
    repeat (CPB + 3 * CPB + 5) @(negedge clk);
    chk("arst_pre_tx", 32'(tx), 32'd0);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dropped", 32'(dropped), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(tbl[1]);
    pulse_report("arst_after");
    capture(-1, -1, got, bcyc, ndrop, ferr);
    check_frame("arst_after", got, tbl[1].expb, bcyc, ferr, ndrop, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
